// File: rtl/ps2_kbd_decoder.sv
// PS/2 keyboard receiver: synchronises the pins, deframes 11-bit frames, folds
// E0/F0 prefixes into key events, optionally drops typematic repeats, and queues events in a FWFT FIFO.
module ps2_kbd_decoder #(
    parameter int FIFO_DEPTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FILTER_REPEAT  = 1,
    parameter int ERR_CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ps2_clk,
    input  logic                 ps2_data,
    input  logic                 pop,
    output logic                 key_valid,
    output logic [7:0]           key_code,
    output logic                 key_ext,
    output logic                 key_break,
    output logic                 overflow,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_E0,
        ST_F0,
        ST_E0F0
    } state_t;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // ---------------- synchronisers and edge detect ----------------
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic                   ps2_clk_s, ps2_data_s, fall;

    always_comb begin
        clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
        ps2_clk_s  = clk_sync_q[SYNC_STAGES-1];
        ps2_data_s = dat_sync_q[SYNC_STAGES-1];
        clk_prev_d = ps2_clk_s;
        fall       = clk_prev_q & ~ps2_clk_s;
    end

    // ---------------- deframer ----------------
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [9:0]           frame_q, frame_d;
    logic [TW-1:0]        idle_q, idle_d;
    logic                 byte_vld_q, byte_vld_d;
    logic [7:0]           byte_q, byte_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic                 err_inc, frame_ok;

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        frame_d    = frame_q;
        idle_d     = idle_q;
        byte_vld_d = 1'b0;
        byte_d     = byte_q;
        err_inc    = 1'b0;
        // start low, stop (the live sample) high, odd parity across data+parity
        frame_ok   = ~frame_q[0] & ps2_data_s & (^frame_q[9:1]);
        if (fall) begin
            idle_d = '0;
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = '0;
                if (frame_ok) begin
                    byte_vld_d = 1'b1;
                    byte_d     = frame_q[8:1];
                end else begin
                    err_inc = 1'b1;
                end
            end else begin
                frame_d[bit_cnt_q] = ps2_data_s;
                bit_cnt_d          = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
                idle_d    = '0;
                bit_cnt_d = '0;
                err_inc   = 1'b1;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
        err_d = err_inc ? sat_inc(err_q) : err_q;
    end

    // ---------------- prefix decoder FSM ----------------
    state_t state_q, state_d;
    logic   ev_vld, ev_ext, ev_brk;

    always_comb begin
        state_d = state_q;
        ev_vld  = 1'b0;
        ev_ext  = 1'b0;
        ev_brk  = 1'b0;
        if (byte_vld_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (byte_q == 8'hE0)      state_d = ST_E0;
                    else if (byte_q == 8'hF0) state_d = ST_F0;
                    else                      ev_vld  = 1'b1;
                end
                ST_E0: begin
                    if (byte_q == 8'hF0) begin
                        state_d = ST_E0F0;
                    end else if (byte_q != 8'hE0) begin
                        ev_vld  = 1'b1;
                        ev_ext  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_F0, ST_E0F0: begin
                    // a prefix after F0 is a protocol error: silently resync
                    state_d = ST_IDLE;
                    if (byte_q != 8'hE0 && byte_q != 8'hF0) begin
                        ev_vld = 1'b1;
                        ev_brk = 1'b1;
                        ev_ext = (state_q == ST_E0F0);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // ---------------- repeat filter ----------------
    logic       held_vld_q, held_vld_d;
    logic [8:0] held_key_q, held_key_d;
    logic       push, held_match;

    always_comb begin
        held_vld_d = held_vld_q;
        held_key_d = held_key_q;
        push       = 1'b0;
        held_match = held_vld_q && (held_key_q == {ev_ext, byte_q});
        if (ev_vld) begin
            if (ev_brk) begin
                push = 1'b1;
                if (held_match) held_vld_d = 1'b0;
            end else if (FILTER_REPEAT != 0 && held_match) begin
                push = 1'b0;
            end else begin
                push       = 1'b1;
                held_vld_d = 1'b1;
                held_key_d = {ev_ext, byte_q};
            end
        end
    end

    // ---------------- event FIFO ----------------
    logic [9:0]  fifo_mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        ovf_q, ovf_d;
    logic        full, empty, do_push, do_pop;
    logic [9:0]  head, fifo_wdata;

    always_comb begin
        empty      = (wr_ptr_q == rd_ptr_q);
        full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop     = pop & ~empty;
        do_push    = push & (~full | do_pop);
        ovf_d      = ovf_q | (push & full & ~do_pop);
        wr_ptr_d   = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        fifo_wdata = {ev_ext, ev_brk, byte_q};
        head       = fifo_mem_q[rd_ptr_q[AW-1:0]];
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
            bit_cnt_q  <= '0;
            idle_q     <= '0;
            byte_vld_q <= 1'b0;
            err_q      <= '0;
            state_q    <= ST_IDLE;
            held_vld_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ovf_q      <= 1'b0;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            clk_prev_q <= clk_prev_d;
            bit_cnt_q  <= bit_cnt_d;
            idle_q     <= idle_d;
            byte_vld_q <= byte_vld_d;
            err_q      <= err_d;
            state_q    <= state_d;
            held_vld_q <= held_vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ovf_q      <= ovf_d;
        end
    end

    // Data-only registers: qualified by control state, so they need no reset.
    always_ff @(posedge clk) begin
        frame_q    <= frame_d;
        byte_q     <= byte_d;
        held_key_q <= held_key_d;
        if (do_push) fifo_mem_q[wr_ptr_q[AW-1:0]] <= fifo_wdata;
    end

    // ---------------- outputs ----------------
    always_comb begin
        key_valid = ~empty;
        key_code  = key_valid ? head[7:0] : 8'h00;
        key_break = key_valid & head[8];
        key_ext   = key_valid & head[9];
        overflow  = ovf_q;
        err_cnt   = err_q;
    end

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Bench: three decoder configurations share one PS/2 line; each is checked
// against a byte-level event model (prefix rules, repeat filter, bounded queue).
module tb_ps2_kbd_decoder;

    localparam int TO = 300;

    logic       clk = 1'b0;
    logic       rst_n, ps2_clk, ps2_data;
    logic [2:0] pop_v;
    logic       kv [3];
    logic [7:0] kc [3];
    logic       ke [3];
    logic       kb [3];
    logic       ov [3];
    logic [7:0] er [3];

    always #5 clk = ~clk;

    ps2_kbd_decoder #(.FIFO_DEPTH(8), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TO), .FILTER_REPEAT(1), .ERR_CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .pop(pop_v[0]),
        .key_valid(kv[0]), .key_code(kc[0]), .key_ext(ke[0]), .key_break(kb[0]),
        .overflow(ov[0]), .err_cnt(er[0]));
    ps2_kbd_decoder #(.FIFO_DEPTH(8), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TO), .FILTER_REPEAT(0), .ERR_CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .pop(pop_v[1]),
        .key_valid(kv[1]), .key_code(kc[1]), .key_ext(ke[1]), .key_break(kb[1]),
        .overflow(ov[1]), .err_cnt(er[1]));
    ps2_kbd_decoder #(.FIFO_DEPTH(4), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TO), .FILTER_REPEAT(0), .ERR_CNT_W(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .pop(pop_v[2]),
        .key_valid(kv[2]), .key_code(kc[2]), .key_ext(ke[2]), .key_break(kb[2]),
        .overflow(ov[2]), .err_cnt(er[2]));

    int tests = 0;
    int failed = 0;

    // ---------------- reference model ----------------
    int         depth [3] = '{8, 8, 4};
    int         filt  [3] = '{1, 0, 0};
    logic [9:0] em    [3][64];
    int         eh    [3];
    int         en    [3];
    bit         eov   [3];
    bit         hv    [3];
    logic [8:0] hk    [3];
    int         m_err;
    bit         m_ext, m_brk;

    function automatic void m_reset();
        for (int d = 0; d < 3; d++) begin
            eh[d] = 0; en[d] = 0; eov[d] = 1'b0; hv[d] = 1'b0; hk[d] = '0;
        end
        m_err = 0; m_ext = 1'b0; m_brk = 1'b0;
    endfunction

    function automatic void m_push(int d, logic [9:0] e);
        if (en[d] == depth[d]) eov[d] = 1'b1;
        else begin
            em[d][(eh[d] + en[d]) % 64] = e;
            en[d]++;
        end
    endfunction

    function automatic void m_event(logic ext, logic brk, logic [7:0] code);
        for (int d = 0; d < 3; d++) begin
            if (brk) begin
                m_push(d, {ext, 1'b1, code});
                if (hv[d] && hk[d] == {ext, code}) hv[d] = 1'b0;
            end else if (!(filt[d] != 0 && hv[d] && hk[d] == {ext, code})) begin
                m_push(d, {ext, 1'b0, code});
                hv[d] = 1'b1;
                hk[d] = {ext, code};
            end
        end
    endfunction

    function automatic void m_byte(logic [7:0] b);
        if (b == 8'hE0) begin
            if (m_brk) begin m_ext = 1'b0; m_brk = 1'b0; end
            else m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            if (m_brk) begin m_ext = 1'b0; m_brk = 1'b0; end
            else m_brk = 1'b1;
        end else begin
            m_event(m_ext, m_brk, b);
            m_ext = 1'b0; m_brk = 1'b0;
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [10:0] fr, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = fr[i];
            repeat (4) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (8) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    function automatic logic [10:0] mk_frame(logic [7:0] b, bit bad);
        return {1'b1, (~^b) ^ bad, b, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] b, input bit bad);
        send_bits(mk_frame(b, bad), 11);
        ps2_data = 1'b1;
        repeat (6) @(negedge clk);
        if (bad) m_err = (m_err == 255) ? 255 : m_err + 1;
        else m_byte(b);
    endtask

    task automatic pop_one(input int d, input string tag);
        chk($sformatf("%s_d%0d_valid", tag, d), 32'(kv[d]), 32'(en[d] != 0));
        if (en[d] != 0) begin
            chk($sformatf("%s_d%0d_head", tag, d), {22'd0, ke[d], kb[d], kc[d]}, 32'(em[d][eh[d]]));
            pop_v[d] = 1'b1;
            @(negedge clk);
            pop_v[d] = 1'b0;
            eh[d] = (eh[d] + 1) % 64;
            en[d]--;
        end
    endtask

    task automatic check_all(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_d%0d_err", tag, d), 32'(er[d]), 32'(m_err));
            chk($sformatf("%s_d%0d_ovf", tag, d), 32'(ov[d]), 32'(eov[d]));
            while (en[d] != 0) pop_one(d, tag);
            chk($sformatf("%s_d%0d_empty", tag, d), 32'(kv[d]), 32'd0);
            chk($sformatf("%s_d%0d_ovf_after", tag, d), 32'(ov[d]), 32'(eov[d]));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_d%0d_out", tag, d),
                {13'd0, kv[d], ke[d], kb[d], ov[d], kc[d], er[d]}, 32'd0);
        end
    endtask

    // ---------------- directed and random sequence ----------------
    initial begin
        logic [7:0] tbl [6];
        logic [7:0] b;
        tbl = '{8'hE0, 8'hF0, 8'h1C, 8'h1B, 8'h75, 8'h5A};
        rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; pop_v = '0;
        m_reset();
        repeat (5) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // typematic repeats with and without filtering; depth-4 copy overflows
        send_frame(8'h1C, 0); send_frame(8'hF0, 0); send_frame(8'h1C, 0); send_frame(8'h1B, 0);
        send_frame(8'h1B, 0); send_frame(8'h1B, 0); send_frame(8'hF0, 0); send_frame(8'h1B, 0);
        check_all("t1");

        send_frame(8'hE0, 0); send_frame(8'h75, 0);
        send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h75, 0);
        check_all("t2");

        send_frame(8'h1C, 1); send_frame(8'h1B, 0);
        check_all("t3");

        // partial frame abandoned by the idle timeout
        send_bits(mk_frame(8'h33, 0), 4);
        ps2_data = 1'b1;
        repeat (TO + 50) @(negedge clk);
        m_err++;
        send_frame(8'h2A, 0);
        check_all("t4");

        // reset in the middle of a frame
        send_bits(mk_frame(8'h1C, 0), 6);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        m_reset();
        repeat (5) @(negedge clk);
        send_frame(8'h1C, 0);
        check_all("t6");

        send_frame(8'h15, 0); send_frame(8'h1D, 0); send_frame(8'h24, 0);
        send_frame(8'h2D, 0); send_frame(8'h2C, 0); send_frame(8'h35, 0);
        check_all("t5");

        // random traffic with interleaved pops
        for (int i = 0; i < 60; i++) begin
            b = ($urandom_range(0, 4) == 0) ? 8'($urandom) : tbl[$urandom_range(0, 5)];
            send_frame(b, $urandom_range(0, 9) == 0);
            for (int d = 0; d < 3; d++)
                if ($urandom_range(0, 3) == 0) pop_one(d, "rnd");
        end
        check_all("rnd");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
